frac_cen_gen: RTL and testbench

- Parametrised multi-channel fractional clock-enable generator.
- Next generation of the fixed-ratio cen divider that feeds ce_pix into the system block.
- Each channel emits a one-cycle cen pulse at an average rate of clk_sys*N/M, with N/M set at runtime.
- Gives simulation tops and cores pixel, CPU and audio enables from a single clk_sys, with a common resync.

---
 rtl/frac_cen_gen.sv | 114 +++++++++++
 tb/tb_frac_cen_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frac_cen_gen.sv
// Multi-channel fractional clock-enable generator: each channel pulses cen at an average rate of num/den.
// Define FRAC_CEN_DIV2_EN to add cen_half, which fires on every second cen pulse of a channel.
module frac_cen_gen #(
   parameter int CHANNELS = 2,
   parameter int ACC_W    = 16
) (
   input  logic                      clk_sys,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       enable,
   input  logic [CHANNELS*ACC_W-1:0] num,
   input  logic [CHANNELS*ACC_W-1:0] den,
   input  logic                      sync,
   output logic [CHANNELS-1:0]       cen,
   output logic [CHANNELS-1:0]       active
`ifdef FRAC_CEN_DIV2_EN
   ,
   output logic [CHANNELS-1:0]       cen_half
`endif
);

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic [ACC_W-1:0] num_k;
         logic [ACC_W-1:0] den_k;
         logic [ACC_W-1:0] acc_q;
         logic [ACC_W-1:0] acc_d;
         logic [ACC_W:0]   sum;
         logic [ACC_W:0]   diff;
         logic             cen_q;
         logic             cen_d;
         logic             act_q;
         logic             act_d;

         assign num_k = num[gi*ACC_W +: ACC_W];
         assign den_k = den[gi*ACC_W +: ACC_W];
         assign sum   = {1'b0, acc_q} + {1'b0, num_k};
         assign diff  = sum - {1'b0, den_k};

         always_comb begin
            acc_d = acc_q;
            cen_d = 1'b0;
            act_d = 1'b0;
            if (den_k == '0) begin
               acc_d = '0;
            end else if (!enable[gi]) begin
               acc_d = acc_q;
            end else if (num_k >= den_k) begin
               acc_d = '0;
               cen_d = 1'b1;
               act_d = 1'b1;
            end else begin
               act_d = 1'b1;
               if (sum >= {1'b0, den_k}) begin
                  cen_d = 1'b1;
                  // A den lowered mid-run can leave more than one period of excess; drop it.
                  acc_d = (diff >= {1'b0, den_k}) ? '0 : diff[ACC_W-1:0];
               end else begin
                  acc_d = sum[ACC_W-1:0];
               end
            end
            // sync overrides the phase and the pulse but leaves active to the ratio/enable rules
            if (sync) begin
               acc_d = '0;
               cen_d = 1'b0;
            end
         end

         always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
               acc_q <= '0;
               cen_q <= 1'b0;
               act_q <= 1'b0;
            end else begin
               acc_q <= acc_d;
               cen_q <= cen_d;
               act_q <= act_d;
            end
         end

         assign cen[gi]    = cen_q;
         assign active[gi] = act_q;

`ifdef FRAC_CEN_DIV2_EN
         logic tog_q;
         logic tog_d;
         logic half_q;
         logic half_d;

         always_comb begin
            tog_d  = tog_q ^ cen_d;
            half_d = cen_d & tog_q;
            if (sync || (den_k == '0)) begin
               tog_d  = 1'b0;
               half_d = 1'b0;
            end
         end

         always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
               tog_q  <= 1'b0;
               half_q <= 1'b0;
            end else begin
               tog_q  <= tog_d;
               half_q <= half_d;
            end
         end

         assign cen_half[gi] = half_q;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_frac_cen_gen.sv
// Self-checking bench for frac_cen_gen: vector table through a scoreboard queue, then
// async-reset, long-run rate and (when FRAC_CEN_DIV2_EN is defined) cen_half sequences.
module tb_frac_cen_gen;
   localparam int CH = 2;
   localparam int W  = 16;

   logic          clk_sys = 1'b0;
   logic          reset;
   logic          sync;
   logic [CH-1:0] enable;
   logic [CH*W-1:0] num;
   logic [CH*W-1:0] den;
   logic [CH-1:0] cen;
   logic [CH-1:0] active;
`ifdef FRAC_CEN_DIV2_EN
   logic [CH-1:0] cen_half;
`endif

   frac_cen_gen #(.CHANNELS(CH), .ACC_W(W)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .enable  (enable),
      .num     (num),
      .den     (den),
      .sync    (sync),
      .cen     (cen),
      .active  (active)
`ifdef FRAC_CEN_DIV2_EN
      ,
      .cen_half(cen_half)
`endif
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic       s;
      logic [1:0] en;
      logic [15:0] n0, d0, n1, d1;
      logic [1:0] cen;
      logic [1:0] act;
   } vec_t;

   typedef struct {
      logic [1:0] cen;
      logic [1:0] act;
      int         idx;
   } exp_t;

   vec_t tbl[$];
   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   logic [15:0] n0_t, d0_t, n1_t, d1_t;

   function automatic void add(logic s, logic [1:0] en, logic [1:0] c, logic [1:0] a);
      vec_t v;
      v.s = s; v.en = en;
      v.n0 = n0_t; v.d0 = d0_t; v.n1 = n1_t; v.d1 = d1_t;
      v.cen = c; v.act = a;
      tbl.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic drive(input logic s, input logic [1:0] en,
                        input logic [15:0] n0, input logic [15:0] d0,
                        input logic [15:0] n1, input logic [15:0] d1);
      @(negedge clk_sys);
      sync   = s;
      enable = en;
      num    = {n1, n0};
      den    = {d1, d0};
   endtask

   // Drive one cycle, queue the expected outputs, compare them after the next edge.
   task automatic step(input logic s, input logic [1:0] en,
                       input logic [15:0] n0, input logic [15:0] d0,
                       input logic [15:0] n1, input logic [15:0] d1,
                       input logic [1:0] ec, input logic [1:0] ea, input int idx);
      exp_t e;
      drive(s, en, n0, d0, n1, d1);
      e.cen = ec; e.act = ea; e.idx = idx;
      exp_q.push_back(e);
      @(posedge clk_sys);
      #1;
      e = exp_q.pop_front();
      check($sformatf("cen[%0d]", e.idx), 32'(cen), 32'(e.cen));
      check($sformatf("active[%0d]", e.idx), 32'(active), 32'(e.act));
      $display("step %0d: sync=%0b en=%b cen=%b active=%b", e.idx, s, en, cen, active);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] m0, m1;
      int cnt0, cnt1, last0, last1, gmin0, gmax0, gmin1, gmax1;

      reset = 1'b1; sync = 1'b0; enable = '0; num = '0; den = '0;

      // Release from reset: ch0 1/2, ch1 3/8
      n0_t = 16'd1; d0_t = 16'd2; n1_t = 16'd3; d1_t = 16'd8;
      m0 = 16'hAAAA;
      m1 = 16'b1010_0100_1010_0100;
      for (int e = 0; e < 16; e++) add(1'b0, 2'b11, {m1[e], m0[e]}, 2'b11);
      // Sync mid-run
      add(0, 2'b11, 2'b00, 2'b11); add(0, 2'b11, 2'b01, 2'b11);
      add(1, 2'b11, 2'b00, 2'b11);
      add(0, 2'b11, 2'b00, 2'b11); add(0, 2'b11, 2'b01, 2'b11);
      add(0, 2'b11, 2'b10, 2'b11); add(0, 2'b11, 2'b01, 2'b11);
      // Pause ch1 at acc=4 for 5 cycles, then resume
      add(0, 2'b01, 2'b00, 2'b01); add(0, 2'b01, 2'b01, 2'b01); add(0, 2'b01, 2'b00, 2'b01);
      add(0, 2'b01, 2'b01, 2'b01); add(0, 2'b01, 2'b00, 2'b01);
      add(0, 2'b11, 2'b01, 2'b11); add(0, 2'b11, 2'b10, 2'b11);
      // Build ch1 acc=7, then den 8->3 (saturates)
      add(1, 2'b11, 2'b00, 2'b11);
      add(0, 2'b11, 2'b00, 2'b11); add(0, 2'b11, 2'b01, 2'b11); add(0, 2'b11, 2'b10, 2'b11);
      add(0, 2'b11, 2'b01, 2'b11); add(0, 2'b11, 2'b00, 2'b11);
      d1_t = 16'd3;
      add(0, 2'b11, 2'b11, 2'b11); add(0, 2'b11, 2'b10, 2'b11); add(0, 2'b11, 2'b11, 2'b11);
      // Rebuild acc=7, then 1/4: sum 8, 8-4=4 >= 4 so acc clears
      d1_t = 16'd8;
      add(1, 2'b11, 2'b00, 2'b11);
      add(0, 2'b11, 2'b00, 2'b11); add(0, 2'b11, 2'b01, 2'b11); add(0, 2'b11, 2'b10, 2'b11);
      add(0, 2'b11, 2'b01, 2'b11); add(0, 2'b11, 2'b00, 2'b11);
      n1_t = 16'd1; d1_t = 16'd4;
      add(0, 2'b11, 2'b11, 2'b11); add(0, 2'b11, 2'b00, 2'b11); add(0, 2'b11, 2'b01, 2'b11);
      add(0, 2'b11, 2'b00, 2'b11); add(0, 2'b11, 2'b11, 2'b11);
      // ch0 5/5 saturate, then den0=0
      n0_t = 16'd5; d0_t = 16'd5;
      add(0, 2'b11, 2'b01, 2'b11); add(0, 2'b11, 2'b01, 2'b11); add(0, 2'b11, 2'b01, 2'b11);
      d0_t = 16'd0;
      add(0, 2'b11, 2'b10, 2'b10); add(0, 2'b11, 2'b00, 2'b10);
      n0_t = 16'd1; d0_t = 16'd2;
      add(0, 2'b11, 2'b00, 2'b11); add(0, 2'b11, 2'b01, 2'b11);
      // ch1 num=0: never pulses, stays active
      n1_t = 16'd0;
      add(0, 2'b11, 2'b00, 2'b11); add(0, 2'b11, 2'b01, 2'b11); add(0, 2'b11, 2'b00, 2'b11);
      // sync with ch1 disabled: active follows enable
      add(1, 2'b01, 2'b00, 2'b01);
      // num > den saturates
      n0_t = 16'd7; d0_t = 16'd3;
      add(0, 2'b11, 2'b01, 2'b11); add(0, 2'b11, 2'b01, 2'b11);
      // sync with den0=0
      d0_t = 16'd0;
      add(1, 2'b11, 2'b00, 2'b10); add(0, 2'b11, 2'b00, 2'b10);

      // Reset state, including with live inputs applied
      repeat (2) @(posedge clk_sys);
      #1;
      check("reset_cen", 32'(cen), 32'd0);
      check("reset_active", 32'(active), 32'd0);
      @(negedge clk_sys);
      enable = 2'b11; num = {16'd3, 16'd1}; den = {16'd8, 16'd2};
      @(posedge clk_sys);
      #1;
      check("reset_hold_cen", 32'(cen), 32'd0);
      check("reset_hold_active", 32'(active), 32'd0);
      #1 reset = 1'b0;

      foreach (tbl[i])
         step(tbl[i].s, tbl[i].en, tbl[i].n0, tbl[i].d0, tbl[i].n1, tbl[i].d1,
              tbl[i].cen, tbl[i].act, i);

      // Async reset while cen0 is high and ch1 acc=6
      step(1, 2'b11, 16'd1, 16'd2, 16'd3, 16'd8, 2'b00, 2'b11, 100);
      step(0, 2'b11, 16'd1, 16'd2, 16'd3, 16'd8, 2'b00, 2'b11, 101);
      step(0, 2'b11, 16'd1, 16'd2, 16'd3, 16'd8, 2'b01, 2'b11, 102);
      #2 reset = 1'b1;
      #1;
      check("async_reset_cen", 32'(cen), 32'd0);
      check("async_reset_active", 32'(active), 32'd0);
      @(posedge clk_sys);
      #1 reset = 1'b0;
      step(0, 2'b11, 16'd1, 16'd2, 16'd3, 16'd8, 2'b00, 2'b11, 103);
      step(0, 2'b11, 16'd1, 16'd2, 16'd3, 16'd8, 2'b01, 2'b11, 104);
      step(0, 2'b11, 16'd1, 16'd2, 16'd3, 16'd8, 2'b10, 2'b11, 105);

      // Long-run rate and jitter: 7/13 and 11/100 over 1300 cycles
      step(1, 2'b11, 16'd7, 16'd13, 16'd11, 16'd100, 2'b00, 2'b11, 200);
      cnt0 = 0; cnt1 = 0; last0 = -1; last1 = -1;
      gmin0 = 1000; gmax0 = 0; gmin1 = 1000; gmax1 = 0;
      for (int c = 0; c < 1300; c++) begin
         drive(0, 2'b11, 16'd7, 16'd13, 16'd11, 16'd100);
         @(posedge clk_sys);
         #1;
         if (cen[0] === 1'b1) begin
            if (last0 >= 0) begin
               if (c - last0 < gmin0) gmin0 = c - last0;
               if (c - last0 > gmax0) gmax0 = c - last0;
            end
            last0 = c; cnt0++;
         end
         if (cen[1] === 1'b1) begin
            if (last1 >= 0) begin
               if (c - last1 < gmin1) gmin1 = c - last1;
               if (c - last1 > gmax1) gmax1 = c - last1;
            end
            last1 = c; cnt1++;
         end
      end
      $display("rate: ch0 pulses=%0d gaps %0d..%0d, ch1 pulses=%0d gaps %0d..%0d",
               cnt0, gmin0, gmax0, cnt1, gmin1, gmax1);
      check("rate_ch0_count", 32'(cnt0), 32'd700);
      check("rate_ch1_count", 32'(cnt1), 32'd143);
      check("rate_ch0_gap_min", 32'(gmin0), 32'd1);
      check("rate_ch0_gap_max", 32'(gmax0), 32'd2);
      check("rate_ch1_gap_min", 32'(gmin1), 32'd9);
      check("rate_ch1_gap_max", 32'(gmax1), 32'd10);

`ifdef FRAC_CEN_DIV2_EN
      // ch0 at 1/2: cen every 2nd cycle, cen_half every 4th
      step(1, 2'b11, 16'd1, 16'd2, 16'd0, 16'd4, 2'b00, 2'b11, 300);
      check("half_sync", 32'(cen_half[0]), 32'd0);
      for (int k = 1; k <= 12; k++) begin
         drive(0, 2'b11, 16'd1, 16'd2, 16'd0, 16'd4);
         @(posedge clk_sys);
         #1;
         check($sformatf("half_12_cen[%0d]", k), 32'(cen[0]), 32'((k % 2) == 0));
         check($sformatf("half_12_half[%0d]", k), 32'(cen_half[0]), 32'((k % 4) == 0));
         $display("div2 1/2 cycle %0d: cen0=%0b cen_half0=%0b", k, cen[0], cen_half[0]);
      end
      // ch0 at 4/4: cen every cycle, cen_half alternates 0,1
      step(1, 2'b11, 16'd4, 16'd4, 16'd0, 16'd4, 2'b00, 2'b11, 301);
      for (int k = 1; k <= 4; k++) begin
         drive(0, 2'b11, 16'd4, 16'd4, 16'd0, 16'd4);
         @(posedge clk_sys);
         #1;
         check($sformatf("half_sat_cen[%0d]", k), 32'(cen[0]), 32'd1);
         check($sformatf("half_sat_half[%0d]", k), 32'(cen_half[0]), 32'((k % 2) == 0));
         $display("div2 4/4 cycle %0d: cen0=%0b cen_half0=%0b", k, cen[0], cen_half[0]);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
